// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader and memory-port owner.
// Holds the core in reset, receives a framed byte stream of instructions
// (high byte, low byte per word, then one trailing checksum byte), writes
// each word into program memory, verifies the checksum and then hands the
// memory port over to the core.
module prog_loader #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 15
) (
  input  logic                   ph1,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  len,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   core_reset,
  input  logic [ADDR_WIDTH-1:0]  core_adr,
  input  logic                   core_we,
  input  logic [7:0]             core_wdata,
  output logic [ADDR_WIDTH-1:0]  mem_adr,
  output logic                   mem_we,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  // Width of the instruction's upper part, carried in the low bits of the
  // first byte of each word.
  localparam int HI_W = INSTR_WIDTH - 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_RUN   = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] cnt_reg;
  logic [ADDR_WIDTH-1:0] len_reg;
  logic [7:0]            sum_reg;
  logic [HI_W-1:0]       hi_reg;
  logic [7:0]            lo_reg;
  logic                  core_reset_reg;

  logic                  xfer;
  logic [7:0]            sum_next;
  logic [ADDR_WIDTH-1:0] last_idx;
  logic                  in_run;

  // Stream handshake, running checksum and last-word index.
  // len_reg of 0 yields last_idx of all-ones, i.e. a full 2**ADDR_WIDTH load.
  always_comb begin
    xfer     = in_valid & in_ready;
    sum_next = sum_reg + in_data;
    last_idx = len_reg - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    in_run   = (state_reg == S_RUN);
  end

  // Status and handshake outputs decode the current state only, so an
  // asynchronous reset is reflected on them immediately.
  always_comb begin
    in_ready = (state_reg == S_HI) || (state_reg == S_LO) || (state_reg == S_CSUM);
    busy     = (state_reg == S_HI) || (state_reg == S_LO) ||
               (state_reg == S_WRITE) || (state_reg == S_CSUM);
    done     = in_run;
    err      = (state_reg == S_ERR);
  end

  // Memory port mux: the core owns the port only while running; otherwise
  // the loader presents the current word and strobes it in WRITE.
  always_comb begin
    if (in_run) begin
      mem_adr   = core_adr;
      mem_we    = core_we;
      mem_wdata = {{HI_W{1'b0}}, core_wdata};
    end else begin
      mem_adr   = cnt_reg;
      mem_we    = (state_reg == S_WRITE);
      mem_wdata = {hi_reg, lo_reg};
    end
  end

  assign core_reset = core_reset_reg;

  // Load sequencer: byte capture, word write, checksum verdict and the
  // registered core reset, which lags the state by one edge so the core is
  // released one cycle after RUN is entered and re-held one cycle after it
  // is left.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      len_reg        <= '0;
      sum_reg        <= '0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      core_reset_reg <= 1'b1;
    end else begin
      core_reset_reg <= (state_reg != S_RUN);
      case (state_reg)
        S_IDLE, S_RUN, S_ERR: begin
          if (start) begin
            state_reg <= S_HI;
            len_reg   <= len;
            cnt_reg   <= '0;
            sum_reg   <= '0;
          end
        end
        S_HI: begin
          if (xfer) begin
            hi_reg    <= in_data[HI_W-1:0];
            sum_reg   <= sum_next;
            state_reg <= S_LO;
          end
        end
        S_LO: begin
          if (xfer) begin
            lo_reg    <= in_data;
            sum_reg   <= sum_next;
            state_reg <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (cnt_reg == last_idx) begin
            state_reg <= S_CSUM;
          end else begin
            cnt_reg   <= cnt_reg + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            state_reg <= S_HI;
          end
        end
        S_CSUM: begin
          if (xfer) begin
            sum_reg   <= sum_next;
            state_reg <= (sum_next == 8'h00) ? S_RUN : S_ERR;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule
